// File: rtl/vdf_iteration_ctrl.sv
// Drives a single-step modular squarer T times to form x^(2^T) mod M; first sq_start one cycle after accept, result after T*(L+1)+1 cycles.
// Result is held on res_valid until res_ready; no new command is taken until the handshake completes, and abort cancels a job at any point.
module vdf_iteration_ctrl #(
  parameter int MOD_LEN     = 1024,
  parameter int ITER_W      = 64,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [MOD_LEN-1:0] cmd_x,
  input  logic [ITER_W-1:0]  cmd_t,
  input  logic               abort,
  output logic               sq_start,
  output logic [MOD_LEN-1:0] sq_in,
  input  logic [MOD_LEN-1:0] sq_out,
  input  logic               sq_valid,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [MOD_LEN-1:0] res_y,
  output logic [ITER_W-1:0]  res_iters,
  output logic               res_err,
  output logic               busy
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t             state, state_nxt;
  logic [MOD_LEN-1:0] operand;
  logic [ITER_W-1:0]  t_reg;
  logic [ITER_W-1:0]  iter_cnt;
  logic [ITER_W-1:0]  iter_inc;
  logic               err;
  logic [WD_W-1:0]    wdog;
  logic               cmd_rdy_q;
  logic               accept;
  logic               wd_expire;

  // iter_cnt never exceeds t_reg, so the increment cannot wrap
  assign iter_inc  = iter_cnt + ITER_W'(1);
  assign accept    = (state == IDLE) && cmd_rdy_q && cmd_valid && !abort;
  assign wd_expire = (wdog == WD_W'(TIMEOUT_CYC - 1));

  always_comb begin
    state_nxt = state;
    sq_start  = 1'b0;
    sq_in     = operand;
    res_valid = 1'b0;
    res_y     = '0;
    res_iters = '0;
    res_err   = 1'b0;
    busy      = (state != IDLE);
    cmd_ready = cmd_rdy_q;
    case (state)
      IDLE: begin
        if (accept) state_nxt = (cmd_t == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        sq_start  = 1'b1;
        state_nxt = abort ? IDLE : WAIT;
      end
      WAIT: begin
        // a result landing on the expiry cycle still counts as good
        if (abort)          state_nxt = IDLE;
        else if (sq_valid)  state_nxt = (iter_inc == t_reg) ? DONE : ISSUE;
        else if (wd_expire) state_nxt = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        res_y     = operand;
        res_iters = iter_cnt;
        res_err   = err;
        if (abort || res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      operand   <= '0;
      t_reg     <= '0;
      iter_cnt  <= '0;
      err       <= 1'b0;
      wdog      <= '0;
      cmd_rdy_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      cmd_rdy_q <= (state_nxt == IDLE);
      case (state)
        IDLE: begin
          if (accept) begin
            operand  <= cmd_x;
            t_reg    <= cmd_t;
            iter_cnt <= '0;
            err      <= 1'b0;
          end
        end
        ISSUE: wdog <= '0;
        WAIT: begin
          if (!abort) begin
            if (sq_valid) begin
              operand  <= sq_out;
              iter_cnt <= iter_inc;
            end else if (wd_expire) begin
              err <= 1'b1;
            end else begin
              wdog <= wdog + WD_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vdf_iteration_ctrl.sv
// Scoreboard bench for vdf_iteration_ctrl with a latency-4 squarer model.
module tb_vdf_iteration_ctrl;

  localparam int MOD_LEN = 1024;
  localparam int ITER_W  = 64;
  localparam int TMO     = 16;
  localparam int L       = 4;
  localparam logic [MOD_LEN-1:0] M = (1024'd1 << 1023) + 1024'd12345;

  logic               clk = 0;
  logic               reset;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [MOD_LEN-1:0] cmd_x;
  logic [ITER_W-1:0]  cmd_t;
  logic               abort;
  logic               sq_start;
  logic [MOD_LEN-1:0] sq_in;
  logic [MOD_LEN-1:0] sq_out;
  logic               sq_valid;
  logic               res_valid;
  logic               res_ready;
  logic [MOD_LEN-1:0] res_y;
  logic [ITER_W-1:0]  res_iters;
  logic               res_err;
  logic               busy;

  vdf_iteration_ctrl #(.MOD_LEN(MOD_LEN), .ITER_W(ITER_W), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_x(cmd_x), .cmd_t(cmd_t),
    .abort(abort),
    .sq_start(sq_start), .sq_in(sq_in), .sq_out(sq_out), .sq_valid(sq_valid),
    .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y),
    .res_iters(res_iters), .res_err(res_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [MOD_LEN-1:0] y;
    logic [ITER_W-1:0]  it;
    logic               err;
    int                 lat;
    int                 nst;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   budget   = 1000000;
  bit   stray_req = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [MOD_LEN-1:0] act, input logic [MOD_LEN-1:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act[127:0], req[127:0]);
  endtask

  task automatic bound_expired(input string name);
    n_checks++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic logic [MOD_LEN-1:0] sqmod(input logic [MOD_LEN-1:0] a);
    logic [2*MOD_LEN-1:0] p;
    p = {{MOD_LEN{1'b0}}, a} * {{MOD_LEN{1'b0}}, a};
    return MOD_LEN'(p % {{MOD_LEN{1'b0}}, M});
  endfunction

  // Squarer model: captures sq_in on sq_start, answers L edges later
  initial begin
    int mcnt;
    logic [MOD_LEN-1:0] mres;
    mcnt = 0;
    mres = '0;
    sq_valid = 0;
    sq_out = '0;
    forever begin
      @(posedge clk);
      #2;
      sq_valid = 0;
      if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) begin
          sq_valid = 1;
          sq_out   = mres;
        end
      end else if (sq_start && budget > 0) begin
        budget--;
        mcnt = L;
        mres = sqmod(sq_in);
      end
      if (stray_req) begin
        sq_valid  = 1;
        sq_out    = 1024'd12345;
        stray_req = 0;
      end
    end
  end

  // Monitor: timing of starts, latency, and result contents against the scoreboard
  initial begin
    int acc_cyc, n_st, last_sqv;
    bit first_res;
    exp_t e;
    acc_cyc = 0; n_st = 0; last_sqv = -1; first_res = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (cmd_valid && cmd_ready && !abort) begin
          acc_cyc = cyc; n_st = 0; last_sqv = -1; first_res = 1;
        end
        if (sq_start) begin
          if (n_st == 0) check("first_start_delay", cyc - acc_cyc, 1);
          else if (last_sqv >= 0) check("reissue_delay", cyc - last_sqv, 1);
          n_st++;
        end
        if (sq_valid) last_sqv = cyc;
        if (res_valid) begin
          check("cmd_ready_in_done", cmd_ready, 0);
          if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_result: res_y=0x%0h with no result pending", res_y[127:0]);
          end else begin
            e = sb[0];
            check("res_y", res_y, e.y);
            check("res_iters", res_iters, e.it);
            check("res_err", res_err, e.err);
            if (first_res) begin
              if (e.lat >= 0) check("result_latency", cyc - acc_cyc, e.lat);
              if (e.nst >= 0) check("start_count", n_st, e.nst);
              first_res = 0;
            end
            if (res_ready) void'(sb.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [MOD_LEN-1:0] y, input logic [ITER_W-1:0] it,
                      input logic err, input int lat, input int nst);
    exp_t e;
    e.y = y; e.it = it; e.err = err; e.lat = lat; e.nst = nst;
    sb.push_back(e);
  endtask

  task automatic run_cmd(input logic [MOD_LEN-1:0] x, input logic [ITER_W-1:0] t);
    for (int i = 0; i < 100 && !cmd_ready; i++) tick();
    if (!cmd_ready) bound_expired("cmd_ready_wait");
    cmd_valid = 1; cmd_x = x; cmd_t = t;
    tick();
    cmd_valid = 0;
  endtask

  task automatic wait_done(input string name);
    int i;
    for (i = 0; i < 300 && (sb.size() != 0 || busy); i++) tick();
    if (sb.size() != 0 || busy) bound_expired(name);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 0);
    check({tag, "_sq_start"}, sq_start, 0);
    check({tag, "_sq_in"}, sq_in, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_y"}, res_y, 0);
    check({tag, "_res_iters"}, res_iters, 0);
    check({tag, "_res_err"}, res_err, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    reset = 1; cmd_valid = 0; cmd_x = '0; cmd_t = '0; abort = 0; res_ready = 1;
    repeat (3) tick();
    check_all_zero("reset");
    reset = 0;
    repeat (2) tick();

    // T = 3: 3^8
    push(1024'd6561, 64'd3, 1'b0, 16, 3);
    run_cmd(1024'd3, 64'd3);
    wait_done("t3_done");

    // T = 0: seed returned untouched
    push(1024'd3, 64'd0, 1'b0, 1, 0);
    run_cmd(1024'd3, 64'd0);
    wait_done("t0_done");

    // T = 5 with consumer stalled, competing command ignored
    res_ready = 0;
    push(1024'd1853020188851841, 64'd5, 1'b0, 26, 5);
    run_cmd(1024'd3, 64'd5);
    for (int i = 0; i < 100 && !res_valid; i++) tick();
    if (!res_valid) bound_expired("t5_res_valid");
    cmd_valid = 1; cmd_x = 1024'd7; cmd_t = 64'd1;
    repeat (10) tick();
    cmd_valid = 0;
    res_ready = 1;
    tick();
    check("post_hs_cmd_ready", cmd_ready, 1);
    check("post_hs_res_valid", res_valid, 0);
    check("post_hs_pending", sb.size(), 0);

    // abort during second WAIT of a long job
    run_cmd(1024'd3, 64'd100);
    repeat (7) tick();
    abort = 1;
    tick();
    abort = 0;
    check("abort_busy", busy, 0);
    check("abort_sq_start", sq_start, 0);
    check("abort_res_valid", res_valid, 0);
    check("abort_cmd_ready", cmd_ready, 1);
    repeat (4) tick();
    check("late_valid_busy", busy, 0);
    check("late_valid_operand", sq_in, 1024'd9);
    push(1024'd9, 64'd1, 1'b0, 6, 1);
    run_cmd(1024'd3, 64'd1);
    wait_done("after_abort_done");

    // squarer answers once then stalls: watchdog error
    budget = 1;
    push(1024'd9, 64'd1, 1'b1, -1, 2);
    run_cmd(1024'd3, 64'd4);
    wait_done("timeout_done");
    budget = 1000000;
    repeat (6) tick();

    // reset in WAIT of iteration 2
    run_cmd(1024'd3, 64'd4);
    repeat (7) tick();
    reset = 1;
    tick();
    check_all_zero("midjob_reset");
    repeat (2) tick();
    reset = 0;
    repeat (2) tick();
    stray_req = 1;
    repeat (2) tick();
    check("stray_busy", busy, 0);
    check("stray_operand", sq_in, 0);
    check("stray_res_valid", res_valid, 0);
    push(1024'd81, 64'd2, 1'b0, 11, 2);
    run_cmd(1024'd3, 64'd2);
    wait_done("after_reset_done");

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
